seg_disp_sched: RTL and testbench

//  Shares the 8-digit serial 7-segment display (two chained 74HC595) between NREQ measurement sources.

---
 rtl/seg_disp_sched_pkg.sv | 26 ++
 rtl/seg_disp_sched_if.sv | 10 +
 rtl/seg_disp_sched_shift595.sv | 104 ++++++++++
 rtl/seg_disp_sched.sv | 129 ++++++++++++
 tb/tb_seg_disp_sched.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_disp_sched_pkg.sv
// rtl/seg_disp_sched_pkg.sv - glyph table, digit word builder and shifter state type
package seg_disp_sched_pkg;

  // Digit-select byte for digit 0; digit d uses this shifted right by d
  localparam logic [7:0] DIG_BASE = 8'h80;

  // Active-low segment glyphs for hex nibbles 0..F
  localparam logic [7:0] SEGT [16] = '{
    8'h03, 8'h9f, 8'h25, 8'h0d, 8'h99, 8'h49, 8'h41, 8'h1f,
    8'h01, 8'h09, 8'h11, 8'hc1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  typedef enum logic [2:0] {
    S_LOAD,
    S_BIT_LO,
    S_BIT_HI,
    S_LAT_HI,
    S_LAT_LO
  } shift_state_t;

  // 16-bit word for one digit: select byte above, glyph below
  function automatic logic [15:0] digit_word(input logic [2:0] d, input logic [3:0] nib);
    return {DIG_BASE >> d, SEGT[nib]};
  endfunction

endpackage

// File: rtl/seg_disp_sched_if.sv
// rtl/seg_disp_sched_if.sv - measurement source snapshot bus
interface seg_disp_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    src_vld;
  logic [NREQ*32-1:0] src_val;

  modport master (output src_vld, output src_val);
  modport slave  (input  src_vld, input  src_val);
endinterface

// File: rtl/seg_disp_sched_shift595.sv
// rtl/seg_disp_sched_shift595.sv - serialises one 16-bit word into a 74HC595 chain
module seg_shift595 import seg_disp_sched_pkg::*; #(
  parameter int SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] word,
  input  logic        start,
  output logic        done,
  output logic        ds,
  output logic        shclk,
  output logic        stclk
);

  localparam int CW = (SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;
  localparam logic [CW-1:0] HALF = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] FULL = CW'(2 * SCLK_DIV - 1);

  shift_state_t   state;
  logic [CW-1:0]  cnt;
  logic [3:0]     bit_idx;
  logic [15:0]    sh;

  // Word is taken either from idle or on the last latch-low cycle, so digits run back to back
  assign done = start && ((state == S_LOAD) || (state == S_LAT_LO && cnt == FULL));

  // Bit/latch sequencer; ds only moves on the edge where shclk goes (or stays) low
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_LOAD;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      ds      <= 1'b0;
      shclk   <= 1'b0;
      stclk   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (start) begin
            sh      <= word;
            ds      <= word[0];
            bit_idx <= '0;
            cnt     <= '0;
            state   <= S_BIT_LO;
          end
        end
        S_BIT_LO: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            shclk <= 1'b1;
            state <= S_BIT_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BIT_HI: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            shclk <= 1'b0;
            if (bit_idx == 4'd15) begin
              state <= S_LAT_HI;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              sh      <= {1'b0, sh[15:1]};
              ds      <= sh[1];
              state   <= S_BIT_LO;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LAT_HI: begin
          // One half-period of setup after the last shift, then the latch pulse
          if (cnt == HALF) stclk <= 1'b1;
          if (cnt == FULL) begin
            stclk <= 1'b0;
            cnt   <= '0;
            state <= S_LAT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LAT_LO: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (start) begin
              sh      <= word;
              ds      <= word[0];
              bit_idx <= '0;
              state   <= S_BIT_LO;
            end else begin
              state <= S_LOAD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// rtl/seg_disp_sched.sv - shares an 8-digit 595 display between NREQ measurement sources
module seg_disp_sched import seg_disp_sched_pkg::*; #(
  parameter int NREQ       = 4,
  parameter int SCLK_DIV   = 4,
  parameter int DB_CYCLES  = 1000000,
  parameter int ROT_FRAMES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_next,
  input  logic             key_mode,
  seg_disp_sched_if.slave  src,
  output logic             ds,
  output logic             shclk,
  output logic             stclk,
  output logic [3:0]       led
);

  localparam int SW = $clog2(NREQ);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int FW = $clog2(ROT_FRAMES + 1);

  logic [31:0]   snap [NREQ];
  logic [31:0]   frame_val;
  logic [31:0]   cur_val;
  logic [SW-1:0] pending;
  logic [SW-1:0] sel;
  logic          auto_mode;
  logic          frame_tgl;
  logic [FW-1:0] frame_cnt;
  logic [2:0]    digit;
  logic [15:0]   word;
  logic          done;
  logic          frame_start;
  logic          rot;
  logic [1:0]    key_raw;
  logic [1:0]    press;

  assign key_raw = {key_mode, key_next};

  // Per-key debouncer: press pulse on an accepted high-to-low level change
  for (genvar k = 0; k < 2; k++) begin : g_db
    logic          s1, s2, lvl, pr;
    logic [DW-1:0] cnt;

    // Two-flop sync, then count consecutive samples that differ from the accepted level
    always_ff @(posedge clk) begin
      if (rst) begin
        s1  <= 1'b1;
        s2  <= 1'b1;
        lvl <= 1'b1;
        pr  <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= key_raw[k];
        s2 <= s1;
        pr <= 1'b0;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == DW'(DB_CYCLES - 1)) begin
          lvl <= s2;
          cnt <= '0;
          pr  <= lvl;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[k] = pr;
  end

  // Digit 0 reads the live snapshot because frame_val is only captured on that same edge
  assign cur_val     = (digit == 3'd0) ? snap[pending] : frame_val;
  assign word        = digit_word(digit, cur_val[{digit, 2'b00} +: 4]);
  assign frame_start = done && (digit == 3'd0);
  assign rot         = auto_mode && frame_start && (frame_cnt == FW'(ROT_FRAMES - 1));
  assign led         = {frame_tgl, auto_mode, 2'(sel)};

  // Snapshot registers, one per source, updated independently
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) snap[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (src.src_vld[i]) snap[i] <= src.src_val[32*i +: 32];
      end
    end
  end

  // Selection, auto-rotate and frame sequencing; a press and a rotate tick together count once
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      sel       <= '0;
      auto_mode <= 1'b0;
      frame_cnt <= '0;
      frame_tgl <= 1'b0;
      frame_val <= '0;
      digit     <= '0;
    end else begin
      if (press[0] || rot) pending <= pending + SW'(1);
      if (press[1]) begin
        auto_mode <= ~auto_mode;
        frame_cnt <= '0;
      end else if (auto_mode && frame_start) begin
        frame_cnt <= rot ? '0 : frame_cnt + 1'b1;
      end
      if (done) digit <= digit + 3'd1;
      if (frame_start) begin
        sel       <= pending;
        frame_val <= snap[pending];
        frame_tgl <= ~frame_tgl;
      end
    end
  end

  seg_shift595 #(.SCLK_DIV(SCLK_DIV)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .word  (word),
    .start (1'b1),
    .done  (done),
    .ds    (ds),
    .shclk (shclk),
    .stclk (stclk)
  );

endmodule

// File: tb/tb_seg_disp_sched.sv
// tb/tb_seg_disp_sched.sv - scoreboard bench for seg_disp_sched
module tb_seg_disp_sched;

  localparam int NREQ       = 4;
  localparam int SCLK_DIV   = 2;
  localparam int DB_CYCLES  = 16;
  localparam int ROT_FRAMES = 2;
  localparam int DIGIT_CYC  = 36 * SCLK_DIV;
  localparam int FRAME_CYC  = 288 * SCLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_next = 1'b1;
  logic       key_mode = 1'b1;
  logic       ds, shclk, stclk;
  logic [3:0] led;

  seg_disp_sched_if #(.NREQ(NREQ)) src_if ();

  seg_disp_sched #(
    .NREQ(NREQ), .SCLK_DIV(SCLK_DIV), .DB_CYCLES(DB_CYCLES), .ROT_FRAMES(ROT_FRAMES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_next (key_next),
    .key_mode (key_mode),
    .src      (src_if),
    .ds       (ds),
    .shclk    (shclk),
    .stclk    (stclk),
    .led      (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] word;
    logic [3:0]  led;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         fcyc = 0;
  int         frame_no = -1;
  logic [7:0] glyph [16] = '{
    8'h03, 8'h9f, 8'h25, 8'h0d, 8'h99, 8'h49, 8'h41, 8'h1f,
    8'h01, 8'h09, 8'h11, 8'hc1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    fcyc++;
  endtask

  task automatic tick_to(input int n);
    while (fcyc < n) tick();
  endtask

  // One-cycle reset; outputs must be zero right after the reset edge, next edge restarts digit 0
  task automatic reset_dut();
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("rst_ds", ds, 0);
    check("rst_shclk", shclk, 0);
    check("rst_stclk", stclk, 0);
    check("rst_led", led, 0);
    rst = 1'b0;
    tick();
    fcyc = 0;
    frame_no = -1;
  endtask

  // Wait for the next frame start and queue the 8 words that frame must show
  task automatic new_frame(input logic [1:0] s, input logic [31:0] v, input logic a);
    logic [3:0] nib;
    logic       l3;
    if (frame_no >= 0) tick_to(FRAME_CYC);
    fcyc = 0;
    frame_no++;
    l3 = (frame_no % 2 == 0);
    for (int d = 0; d < 8; d++) begin
      nib = v[4*d +: 4];
      exp_q.push_back({{8'h80 >> d, glyph[nib]}, {l3, a, s}});
    end
  endtask

  task automatic pulse_src(input int i, input logic [31:0] v);
    src_if.src_val[32*i +: 32] = v;
    src_if.src_vld[i] = 1'b1;
    tick();
    src_if.src_vld = '0;
  endtask

  // Monitor: rebuild each word from shclk rises and score it at the stclk rise
  int          ncyc = 0;
  int          nb = 0;
  int          last_sh = 0;
  int          last_st = 0;
  bit          have_st = 0;
  logic [15:0] acc = '0;
  logic        p_sh = 1'b0;
  logic        p_st = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      nb = 0;
      p_sh = 1'b0;
      p_st = 1'b0;
      have_st = 0;
    end else begin
      if (shclk && !p_sh) begin
        if (nb < 16) acc[nb] = ds;
        nb++;
        last_sh = ncyc;
      end
      if (stclk && !p_st) begin
        check("latch_delay", ncyc - last_sh, 2 * SCLK_DIV);
        if (have_st) check("word_period", ncyc - last_st, DIGIT_CYC);
        have_st = 1;
        last_st = ncyc;
        check("bit_count", nb, 16);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h want none", acc);
        end else begin
          e = exp_q.pop_front();
          check("word", acc, e.word);
          check("led", led, e.led);
        end
        nb = 0;
      end
      p_sh = shclk;
      p_st = stclk;
    end
  end

  initial begin
    src_if.src_vld = '0;
    src_if.src_val = '0;
    reset_dut();

    // Snapshot loaded mid-frame 0 appears in frame 1 (digit 0 word 809f)
    new_frame(2'd0, 32'h0, 1'b0);
    tick_to(10);
    pulse_src(0, 32'h0000_0001);
    new_frame(2'd0, 32'h0000_0001, 1'b0);

    // Chattering key_next gives one press; selection moves only at the next frame
    tick_to(10);
    for (int t = 0; t < 10; t++) begin
      key_next = ~key_next;
      repeat (3) tick();
    end
    key_next = 1'b0;
    repeat (20) tick();
    key_next = 1'b1;
    new_frame(2'd1, 32'h0, 1'b0);

    // Auto mode: rotate every 2 frames, wrapping after source 3
    reset_dut();
    new_frame(2'd0, 32'h0, 1'b1);
    tick_to(2);
    key_mode = 1'b0;
    tick_to(40);
    key_mode = 1'b1;
    for (int k = 1; k <= 9; k++) new_frame(2'(((k - 1) / 2) % 4), 32'h0, 1'b1);

    // key_next press lands on the same edge as the rotate tick: one step only
    tick_to(FRAME_CYC - 19);
    key_next = 1'b0;
    new_frame(2'd0, 32'h0, 1'b1);
    tick_to(20);
    key_next = 1'b1;
    new_frame(2'd1, 32'h0, 1'b1);

    // Mid-frame update never tears; update on the frame-start edge waits a frame
    tick_to(100);
    pulse_src(1, 32'hFEDC_BA98);
    new_frame(2'd1, 32'hFEDC_BA98, 1'b1);
    tick_to(FRAME_CYC - 1);
    pulse_src(2, 32'h1234_5678);
    new_frame(2'd2, 32'h0, 1'b1);
    new_frame(2'd2, 32'h1234_5678, 1'b1);
    new_frame(2'd3, 32'h0, 1'b1);

    // Reset at digit 3 bit 7: partial word dropped, display restarts cleared at digit 0
    tick_to(3 * DIGIT_CYC + 7 * 2 * SCLK_DIV + 2);
    reset_dut();
    new_frame(2'd0, 32'h0, 1'b0);
    tick_to(FRAME_CYC);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
